// File: rtl/sys_ctrl_pkg.sv
// Shared opcodes, state encoding and fixed operand addresses for the
// sys_ctrl command sequencer.
package sys_ctrl_pkg;

  localparam logic [7:0] OP_RF_WR   = 8'hAA;
  localparam logic [7:0] OP_RF_RD   = 8'hBB;
  localparam logic [7:0] OP_ALU_OP  = 8'hCC;
  localparam logic [7:0] OP_ALU_NOP = 8'hDD;

  localparam int RF_ADDR_A     = 0;
  localparam int RF_ADDR_B     = 1;
  localparam int ALU_FUN_WIDTH = 4;
  localparam int TIMER_WIDTH   = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_ALU_A,
    ST_ALU_B,
    ST_ALU_FUN,
    ST_ALU_WAIT,
    ST_TX_LO,
    ST_TX_HI
  } state_t;

endpackage

// File: rtl/sys_ctrl_tx_push.sv
// Response byte holder: keeps up to two bytes (low first) and pushes them
// into the TX FIFO whenever it is not full.
module sys_ctrl_tx_push #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [2*DATA_WIDTH-1:0] load_data,
  input  logic                    load_two,
  input  logic                    f_full,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_push,
  output logic                    tx_done
);

  logic [2*DATA_WIDTH-1:0] byte_buf_q;
  logic [1:0]              cnt_q;

  // Push is combinational so that a full FIFO blocks it in the same cycle.
  assign tx_push = (cnt_q != 2'd0) & ~f_full;
  assign tx_done = tx_push & (cnt_q == 2'd1);
  assign tx_data = byte_buf_q[DATA_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_buf_q <= '0;
      cnt_q      <= 2'd0;
    end else if (load) begin
      byte_buf_q <= load_data;
      cnt_q      <= load_two ? 2'd2 : 2'd1;
    end else if (tx_push) begin
      byte_buf_q <= {{DATA_WIDTH{1'b0}}, byte_buf_q[2*DATA_WIDTH-1:DATA_WIDTH]};
      cnt_q      <= cnt_q - 2'd1;
    end
  end

endmodule

// File: rtl/sys_ctrl.sv
// Command sequencer: decodes RX byte commands into register-file writes/reads
// and ALU operations, and queues response bytes for the TX FIFO.
module sys_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                     REF_CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  output logic [ADDR_WIDTH-1:0]    RF_ADDR,
  output logic                     RF_WR_EN,
  output logic [DATA_WIDTH-1:0]    RF_WR_DATA,
  output logic                     RF_RD_EN,
  input  logic [DATA_WIDTH-1:0]    RF_RD_DATA,
  input  logic                     RF_RD_DATA_VLD,
  output logic [ALU_FUN_WIDTH-1:0] ALU_FUN,
  output logic                     ALU_EN,
  input  logic [2*DATA_WIDTH-1:0]  ALU_OUT,
  input  logic                     ALU_OUT_VLD,
  output logic [DATA_WIDTH-1:0]    SYS_UART_TX_IN,
  output logic                     F_WR_INC,
  input  logic                     F_FULL,
  output logic                     ERR
);

  state_t                  state_q, state_d;
  logic [TIMER_WIDTH-1:0]  wait_cnt_q;
  logic [ADDR_WIDTH-1:0]   rf_addr_d;
  logic [DATA_WIDTH-1:0]   rf_wr_data_d;
  logic [ALU_FUN_WIDTH-1:0] alu_fun_d;
  logic                    rf_wr_en_d, rf_rd_en_d, alu_en_d, err_d;
  logic                    tx_load, tx_load_two, tx_done;
  logic [2*DATA_WIDTH-1:0] tx_load_data;
  logic                    in_wait, timeout_hit;

  assign in_wait     = (state_q == ST_RD_WAIT) || (state_q == ST_ALU_WAIT);
  assign timeout_hit = (wait_cnt_q == TIMER_WIDTH'(TIMEOUT - 1));

  sys_ctrl_tx_push #(.DATA_WIDTH(DATA_WIDTH)) u_tx_push (
    .clk       (REF_CLK),
    .rst_n     (RST),
    .load      (tx_load),
    .load_data (tx_load_data),
    .load_two  (tx_load_two),
    .f_full    (F_FULL),
    .tx_data   (SYS_UART_TX_IN),
    .tx_push   (F_WR_INC),
    .tx_done   (tx_done)
  );

  always_comb begin
    state_d      = state_q;
    rf_addr_d    = RF_ADDR;
    rf_wr_data_d = RF_WR_DATA;
    alu_fun_d    = ALU_FUN;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    alu_en_d     = 1'b0;
    err_d        = 1'b0;
    tx_load      = 1'b0;
    tx_load_two  = 1'b0;
    tx_load_data = '0;
    case (state_q)
      ST_IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == DATA_WIDTH'(OP_RF_WR))        state_d = ST_WR_ADDR;
          else if (RX_P_DATA == DATA_WIDTH'(OP_RF_RD))   state_d = ST_RD_ADDR;
          else if (RX_P_DATA == DATA_WIDTH'(OP_ALU_OP))  state_d = ST_ALU_A;
          else if (RX_P_DATA == DATA_WIDTH'(OP_ALU_NOP)) state_d = ST_ALU_FUN;
          else                                           err_d   = 1'b1;
        end
      end
      ST_WR_ADDR: if (RX_D_VLD) begin
        rf_addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
        state_d   = ST_WR_DATA;
      end
      ST_WR_DATA: if (RX_D_VLD) begin
        rf_wr_data_d = RX_P_DATA;
        rf_wr_en_d   = 1'b1;
        state_d      = ST_IDLE;
      end
      ST_RD_ADDR: if (RX_D_VLD) begin
        rf_addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
        rf_rd_en_d = 1'b1;
        state_d    = ST_RD_WAIT;
      end
      // A valid arriving in the last counted cycle still wins over the timeout.
      ST_RD_WAIT: begin
        if (RF_RD_DATA_VLD) begin
          tx_load      = 1'b1;
          tx_load_data = {{DATA_WIDTH{1'b0}}, RF_RD_DATA};
          state_d      = ST_TX_LO;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_ALU_A: if (RX_D_VLD) begin
        rf_addr_d    = ADDR_WIDTH'(RF_ADDR_A);
        rf_wr_data_d = RX_P_DATA;
        rf_wr_en_d   = 1'b1;
        state_d      = ST_ALU_B;
      end
      ST_ALU_B: if (RX_D_VLD) begin
        rf_addr_d    = ADDR_WIDTH'(RF_ADDR_B);
        rf_wr_data_d = RX_P_DATA;
        rf_wr_en_d   = 1'b1;
        state_d      = ST_ALU_FUN;
      end
      ST_ALU_FUN: if (RX_D_VLD) begin
        alu_fun_d = RX_P_DATA[ALU_FUN_WIDTH-1:0];
        alu_en_d  = 1'b1;
        state_d   = ST_ALU_WAIT;
      end
      ST_ALU_WAIT: begin
        if (ALU_OUT_VLD) begin
          tx_load      = 1'b1;
          tx_load_two  = 1'b1;
          tx_load_data = ALU_OUT;
          state_d      = ST_TX_LO;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_TX_LO: begin
        if (tx_done)       state_d = ST_IDLE;
        else if (F_WR_INC) state_d = ST_TX_HI;
      end
      ST_TX_HI: if (F_WR_INC) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The wait counter only runs while staying in a wait state, so it is zero on entry.
  always_ff @(posedge REF_CLK) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      RF_ADDR    <= '0;
      RF_WR_DATA <= '0;
      ALU_FUN    <= '0;
      RF_WR_EN   <= 1'b0;
      RF_RD_EN   <= 1'b0;
      ALU_EN     <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= (in_wait && state_d == state_q) ? wait_cnt_q + 1'b1 : '0;
      RF_ADDR    <= rf_addr_d;
      RF_WR_DATA <= rf_wr_data_d;
      ALU_FUN    <= alu_fun_d;
      RF_WR_EN   <= rf_wr_en_d;
      RF_RD_EN   <= rf_rd_en_d;
      ALU_EN     <= alu_en_d;
      ERR        <= err_d;
    end
  end

endmodule

// File: tb/tb_sys_ctrl.sv
// Directed self-checking bench for sys_ctrl: commands, responses, FIFO
// backpressure, errors, timeout and reset behaviour.
module tb_sys_ctrl;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 4;
  localparam int TIMEOUT    = 255;

  logic                    ref_clk = 1'b0;
  logic                    rst = 1'b0;
  logic [DATA_WIDTH-1:0]   rx_p_data = '0;
  logic                    rx_d_vld = 1'b0;
  logic [ADDR_WIDTH-1:0]   rf_addr;
  logic                    rf_wr_en;
  logic [DATA_WIDTH-1:0]   rf_wr_data;
  logic                    rf_rd_en;
  logic [DATA_WIDTH-1:0]   rf_rd_data = '0;
  logic                    rf_rd_data_vld = 1'b0;
  logic [3:0]              alu_fun;
  logic                    alu_en;
  logic [2*DATA_WIDTH-1:0] alu_out = '0;
  logic                    alu_out_vld = 1'b0;
  logic [DATA_WIDTH-1:0]   sys_uart_tx_in;
  logic                    f_wr_inc;
  logic                    f_full = 1'b0;
  logic                    err;

  int errors = 0;
  int checks = 0;

  always #5 ref_clk = ~ref_clk;

  sys_ctrl #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .REF_CLK        (ref_clk),
    .RST            (rst),
    .RX_P_DATA      (rx_p_data),
    .RX_D_VLD       (rx_d_vld),
    .RF_ADDR        (rf_addr),
    .RF_WR_EN       (rf_wr_en),
    .RF_WR_DATA     (rf_wr_data),
    .RF_RD_EN       (rf_rd_en),
    .RF_RD_DATA     (rf_rd_data),
    .RF_RD_DATA_VLD (rf_rd_data_vld),
    .ALU_FUN        (alu_fun),
    .ALU_EN         (alu_en),
    .ALU_OUT        (alu_out),
    .ALU_OUT_VLD    (alu_out_vld),
    .SYS_UART_TX_IN (sys_uart_tx_in),
    .F_WR_INC       (f_wr_inc),
    .F_FULL         (f_full),
    .ERR            (err)
  );

  // Event logs sampled mid-cycle; tests compare against deltas from a mark.
  int                    cyc = 0;
  logic [ADDR_WIDTH-1:0] wr_addr_log[$];
  logic [DATA_WIDTH-1:0] wr_data_log[$];
  int                    wr_cyc_log[$];
  logic [ADDR_WIDTH-1:0] rd_addr_log[$];
  logic [3:0]            fun_log[$];
  int                    alu_cyc_log[$];
  logic [DATA_WIDTH-1:0] push_log[$];
  int                    err_cyc_log[$];
  int                    full_push = 0;

  always @(negedge ref_clk) begin
    cyc = cyc + 1;
    if (rf_wr_en) begin
      wr_addr_log.push_back(rf_addr);
      wr_data_log.push_back(rf_wr_data);
      wr_cyc_log.push_back(cyc);
    end
    if (rf_rd_en) rd_addr_log.push_back(rf_addr);
    if (alu_en) begin
      fun_log.push_back(alu_fun);
      alu_cyc_log.push_back(cyc);
    end
    if (f_wr_inc) push_log.push_back(sys_uart_tx_in);
    if (f_wr_inc && f_full) full_push = full_push + 1;
    if (err) err_cyc_log.push_back(cyc);
  end

  int wb, rb, ab, pb, eb, fb;

  task automatic mark();
    wb = wr_addr_log.size();
    rb = rd_addr_log.size();
    ab = fun_log.size();
    pb = push_log.size();
    eb = err_cyc_log.size();
    fb = full_push;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge ref_clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_p_data = b;
    rx_d_vld  = 1'b1;
    tick();
    rx_d_vld  = 1'b0;
    rx_p_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(2);
    @(negedge ref_clk);
    checks++;
    if ({rf_wr_en, rf_rd_en, alu_en, f_wr_inc, err} !== 5'b0) begin
      errors++; $display("[TB] FAIL reset_strobes: got %b expected 00000", {rf_wr_en, rf_rd_en, alu_en, f_wr_inc, err});
    end
    checks++;
    if (rf_addr !== 4'h0) begin errors++; $display("[TB] FAIL reset_rf_addr: got %h expected 0", rf_addr); end
    checks++;
    if (rf_wr_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_wr_data: got %h expected 00", rf_wr_data); end
    checks++;
    if (alu_fun !== 4'h0) begin errors++; $display("[TB] FAIL reset_alu_fun: got %h expected 0", alu_fun); end
    checks++;
    if (sys_uart_tx_in !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_data: got %h expected 00", sys_uart_tx_in); end
    @(posedge ref_clk);
    #1;
    rst = 1'b1;
    tick(2);
  endtask

  task automatic test_wr_rd();
    mark();
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    @(negedge ref_clk);
    checks++;
    if (rf_wr_en !== 1'b1) begin errors++; $display("[TB] FAIL wr_strobe_timing: got %b expected 1", rf_wr_en); end
    checks++;
    if (rf_addr !== 4'h5) begin errors++; $display("[TB] FAIL wr_addr: got %h expected 5", rf_addr); end
    checks++;
    if (rf_wr_data !== 8'h3C) begin errors++; $display("[TB] FAIL wr_data: got %h expected 3c", rf_wr_data); end
    tick(2);
    send_byte(8'hBB); send_byte(8'h05);
    tick(2);
    rf_rd_data = 8'h3C; rf_rd_data_vld = 1'b1;
    tick();
    rf_rd_data_vld = 1'b0; rf_rd_data = '0;
    tick(4);
    checks++;
    if (wr_addr_log.size() - wb != 1) begin errors++; $display("[TB] FAIL wr_count: got %0d expected 1", wr_addr_log.size() - wb); end
    checks++;
    if (rd_addr_log.size() - rb != 1) begin errors++; $display("[TB] FAIL rd_count: got %0d expected 1", rd_addr_log.size() - rb); end
    checks++;
    if (rd_addr_log[rb] !== 4'h5) begin errors++; $display("[TB] FAIL rd_addr: got %h expected 5", rd_addr_log[rb]); end
    checks++;
    if (push_log.size() - pb != 1) begin errors++; $display("[TB] FAIL rd_push_count: got %0d expected 1", push_log.size() - pb); end
    checks++;
    if (push_log[pb] !== 8'h3C) begin errors++; $display("[TB] FAIL rd_push_data: got %h expected 3c", push_log[pb]); end
    checks++;
    if (err_cyc_log.size() != eb) begin errors++; $display("[TB] FAIL wr_rd_no_err: got %0d expected 0", err_cyc_log.size() - eb); end
  endtask

  task automatic test_alu_op();
    mark();
    send_byte(8'hCC); send_byte(8'h0A); send_byte(8'h03); send_byte(8'h00);
    tick();
    alu_out = 16'h000D; alu_out_vld = 1'b1;
    tick();
    alu_out_vld = 1'b0; alu_out = '0;
    tick(4);
    checks++;
    if (wr_addr_log.size() - wb != 2) begin errors++; $display("[TB] FAIL alu_wr_count: got %0d expected 2", wr_addr_log.size() - wb); end
    checks++;
    if ({wr_addr_log[wb], wr_data_log[wb]} !== {4'h0, 8'h0A}) begin
      errors++; $display("[TB] FAIL alu_wr_a: got %h:%h expected 0:0a", wr_addr_log[wb], wr_data_log[wb]);
    end
    checks++;
    if ({wr_addr_log[wb+1], wr_data_log[wb+1]} !== {4'h1, 8'h03}) begin
      errors++; $display("[TB] FAIL alu_wr_b: got %h:%h expected 1:03", wr_addr_log[wb+1], wr_data_log[wb+1]);
    end
    checks++;
    if (fun_log.size() - ab != 1) begin errors++; $display("[TB] FAIL alu_en_count: got %0d expected 1", fun_log.size() - ab); end
    checks++;
    if (fun_log[ab] !== 4'h0) begin errors++; $display("[TB] FAIL alu_fun: got %h expected 0", fun_log[ab]); end
    checks++;
    if (!(alu_cyc_log[ab] > wr_cyc_log[wb+1])) begin
      errors++; $display("[TB] FAIL alu_en_order: got cycle %0d expected after %0d", alu_cyc_log[ab], wr_cyc_log[wb+1]);
    end
    checks++;
    if (push_log.size() - pb != 2) begin errors++; $display("[TB] FAIL alu_push_count: got %0d expected 2", push_log.size() - pb); end
    checks++;
    if (push_log[pb] !== 8'h0D) begin errors++; $display("[TB] FAIL alu_push_lo: got %h expected 0d", push_log[pb]); end
    checks++;
    if (push_log[pb+1] !== 8'h00) begin errors++; $display("[TB] FAIL alu_push_hi: got %h expected 00", push_log[pb+1]); end
  endtask

  task automatic test_backpressure();
    mark();
    send_byte(8'hDD); send_byte(8'hF5);
    f_full = 1'b1;
    tick();
    alu_out = 16'hBEEF; alu_out_vld = 1'b1;
    tick();
    alu_out_vld = 1'b0; alu_out = '0;
    tick(20);
    checks++;
    if (push_log.size() != pb || full_push != fb) begin
      errors++; $display("[TB] FAIL bp_no_push: got %0d pushes expected 0", push_log.size() - pb);
    end
    checks++;
    if (sys_uart_tx_in !== 8'hEF) begin errors++; $display("[TB] FAIL bp_hold_data: got %h expected ef", sys_uart_tx_in); end
    f_full = 1'b0;
    tick(4);
    checks++;
    if (push_log.size() - pb != 2) begin errors++; $display("[TB] FAIL bp_push_count: got %0d expected 2", push_log.size() - pb); end
    checks++;
    if ({push_log[pb], push_log[pb+1]} !== 16'hEFBE) begin
      errors++; $display("[TB] FAIL bp_push_order: got %h %h expected ef be", push_log[pb], push_log[pb+1]);
    end
    checks++;
    if (fun_log[ab] !== 4'h5) begin errors++; $display("[TB] FAIL nop_fun: got %h expected 5", fun_log[ab]); end
    checks++;
    if (wr_addr_log.size() != wb) begin errors++; $display("[TB] FAIL nop_no_write: got %0d expected 0", wr_addr_log.size() - wb); end
  endtask

  task automatic test_bad_opcode();
    mark();
    send_byte(8'h55);
    @(negedge ref_clk);
    checks++;
    if (err !== 1'b1) begin errors++; $display("[TB] FAIL bad_op_err: got %b expected 1", err); end
    tick(3);
    checks++;
    if (err_cyc_log.size() - eb != 1) begin errors++; $display("[TB] FAIL bad_op_err_count: got %0d expected 1", err_cyc_log.size() - eb); end
    checks++;
    if ((wr_addr_log.size() - wb) + (rd_addr_log.size() - rb) + (fun_log.size() - ab) + (push_log.size() - pb) != 0) begin
      errors++; $display("[TB] FAIL bad_op_activity: got nonzero activity expected 0");
    end
  endtask

  task automatic test_timeout();
    int c0;
    mark();
    send_byte(8'hBB); send_byte(8'h02);
    c0 = cyc + 1;
    for (int i = 0; i < TIMEOUT + 20 && err_cyc_log.size() == eb; i++) tick();
    tick(3);
    checks++;
    if (err_cyc_log.size() - eb != 1) begin errors++; $display("[TB] FAIL to_err_count: got %0d expected 1", err_cyc_log.size() - eb); end
    checks++;
    if (err_cyc_log.size() == eb || err_cyc_log[eb] != c0 + TIMEOUT) begin
      errors++; $display("[TB] FAIL to_err_cycle: got %0d expected %0d", (err_cyc_log.size() == eb) ? -1 : err_cyc_log[eb] - c0, TIMEOUT);
    end
    checks++;
    if (push_log.size() != pb) begin errors++; $display("[TB] FAIL to_no_push: got %0d expected 0", push_log.size() - pb); end
    mark();
    send_byte(8'hBB); send_byte(8'h03);
    tick(TIMEOUT - 1);
    rf_rd_data = 8'hA5; rf_rd_data_vld = 1'b1;
    tick();
    rf_rd_data_vld = 1'b0; rf_rd_data = '0;
    tick(3);
    checks++;
    if (err_cyc_log.size() != eb) begin errors++; $display("[TB] FAIL to_prio_err: got %0d expected 0", err_cyc_log.size() - eb); end
    checks++;
    if (push_log.size() - pb != 1 || push_log[pb] !== 8'hA5) begin
      errors++; $display("[TB] FAIL to_prio_push: got %0d pushes first %h expected 1 a5", push_log.size() - pb, push_log[pb]);
    end
  endtask

  task automatic test_reset_mid();
    mark();
    send_byte(8'hAA); send_byte(8'h07);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    send_byte(8'hBB); send_byte(8'h07);
    tick(2);
    rf_rd_data = 8'h99; rf_rd_data_vld = 1'b1;
    tick();
    rf_rd_data_vld = 1'b0; rf_rd_data = '0;
    tick(4);
    checks++;
    if (wr_addr_log.size() != wb) begin errors++; $display("[TB] FAIL rst_mid_no_write: got %0d expected 0", wr_addr_log.size() - wb); end
    checks++;
    if (rd_addr_log.size() - rb != 1 || rd_addr_log[rb] !== 4'h7) begin
      errors++; $display("[TB] FAIL rst_mid_read: got %0d reads addr %h expected 1 7", rd_addr_log.size() - rb, rd_addr_log[rb]);
    end
    checks++;
    if (push_log.size() - pb != 1 || push_log[pb] !== 8'h99) begin
      errors++; $display("[TB] FAIL rst_mid_push: got %0d pushes first %h expected 1 99", push_log.size() - pb, push_log[pb]);
    end
    mark();
    send_byte(8'hDD); send_byte(8'h00);
    f_full = 1'b1;
    tick();
    alu_out = 16'h4321; alu_out_vld = 1'b1;
    tick();
    alu_out_vld = 1'b0; alu_out = '0;
    tick(2);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    f_full = 1'b0;
    tick(4);
    checks++;
    if (push_log.size() != pb) begin errors++; $display("[TB] FAIL rst_tx_no_push: got %0d expected 0", push_log.size() - pb); end
  endtask

  task automatic test_busy_drop();
    mark();
    send_byte(8'hCC); send_byte(8'h11); send_byte(8'h22); send_byte(8'h03);
    tick();
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'hBB);
    tick(2);
    alu_out = 16'h1234; alu_out_vld = 1'b1;
    tick();
    alu_out_vld = 1'b0; alu_out = '0;
    tick(3);
    send_byte(8'hAA); send_byte(8'h09); send_byte(8'h5A);
    tick(3);
    checks++;
    if (err_cyc_log.size() != eb) begin errors++; $display("[TB] FAIL busy_no_err: got %0d expected 0", err_cyc_log.size() - eb); end
    checks++;
    if (wr_addr_log.size() - wb != 3) begin errors++; $display("[TB] FAIL busy_wr_count: got %0d expected 3", wr_addr_log.size() - wb); end
    checks++;
    if ({wr_addr_log[wb+2], wr_data_log[wb+2]} !== {4'h9, 8'h5A}) begin
      errors++; $display("[TB] FAIL busy_next_cmd: got %h:%h expected 9:5a", wr_addr_log[wb+2], wr_data_log[wb+2]);
    end
    checks++;
    if (fun_log.size() - ab != 1 || fun_log[ab] !== 4'h3) begin
      errors++; $display("[TB] FAIL busy_alu: got %0d starts fun %h expected 1 3", fun_log.size() - ab, fun_log[ab]);
    end
    checks++;
    if (push_log.size() - pb != 2 || {push_log[pb], push_log[pb+1]} !== 16'h3412) begin
      errors++; $display("[TB] FAIL busy_push: got %0d pushes %h %h expected 2 34 12", push_log.size() - pb, push_log[pb], push_log[pb+1]);
    end
    checks++;
    if (rd_addr_log.size() != rb) begin errors++; $display("[TB] FAIL busy_no_read: got %0d expected 0", rd_addr_log.size() - rb); end
  endtask

  initial begin
    test_reset();
    test_wr_rd();
    test_alu_op();
    test_backpressure();
    test_bad_opcode();
    test_timeout();
    test_reset_mid();
    test_busy_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
